// File: rtl/bp_nonsynth_host_io_arbiter.sv
// Round-robin merge of per-core io_cmd streams onto the single nonsynth host channel.
// An in-order tag FIFO records each command's source so host responses can be steered back.
module bp_nonsynth_host_io_arbiter
  #(parameter int num_src_p         = 2
   ,parameter int max_outstanding_p = 8
   ,parameter int msg_w_p           = 64
   )
  (input  logic                         clk_i
  ,input  logic                         reset_i

  ,input  logic [num_src_p*msg_w_p-1:0] src_cmd_i
  ,input  logic [num_src_p-1:0]         src_cmd_v_i
  ,output logic [num_src_p-1:0]         src_cmd_ready_o

  ,output logic [num_src_p*msg_w_p-1:0] src_resp_o
  ,output logic [num_src_p-1:0]         src_resp_v_o
  ,input  logic [num_src_p-1:0]         src_resp_yumi_i

  ,output logic [msg_w_p-1:0]           io_cmd_o
  ,output logic                         io_cmd_v_o
  ,input  logic                         io_cmd_ready_i

  ,input  logic [msg_w_p-1:0]           io_resp_i
  ,input  logic                         io_resp_v_i
  ,output logic                         io_resp_yumi_o
  );

  localparam int src_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  function automatic logic [src_w_lp-1:0] wrap_src(input logic [src_w_lp-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= num_src_p) s = s - num_src_p;
    return src_w_lp'(s);
  endfunction

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (int'(p) == max_outstanding_p - 1) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [num_src_p-1:0][msg_w_p-1:0] cmd_arr;
  logic [src_w_lp-1:0] rr_q, rr_d, grant, head;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [src_w_lp-1:0] tag_mem_q [max_outstanding_p];
  logic any_v, can_issue, issue, retire, tag_v, tag_full;

  assign cmd_arr = src_cmd_i;

  // Every outstanding command holds exactly one tag, so the credit count doubles as FIFO occupancy.
  assign tag_v     = (count_q != '0);
  assign tag_full  = (count_q == cnt_w_lp'(max_outstanding_p));
  assign can_issue = ~reset_i & io_cmd_ready_i & ~tag_full;

  always_comb begin
    grant = rr_q;
    any_v = 1'b0;
    for (int i = 0; i < num_src_p; i++) begin
      if (!any_v && src_cmd_v_i[wrap_src(rr_q, i)]) begin
        any_v = 1'b1;
        grant = wrap_src(rr_q, i);
      end
    end
  end

  assign io_cmd_v_o = any_v & can_issue;
  assign io_cmd_o   = cmd_arr[grant];
  assign issue      = io_cmd_v_o & io_cmd_ready_i;

  always_comb begin
    src_cmd_ready_o = '0;
    if (io_cmd_v_o) src_cmd_ready_o[grant] = 1'b1;
  end

  assign head       = tag_mem_q[rptr_q];
  assign src_resp_o = {num_src_p{io_resp_i}};

  always_comb begin
    src_resp_v_o = '0;
    if (~reset_i & io_resp_v_i & tag_v) src_resp_v_o[head] = 1'b1;
  end

  // Only the head bit can be set, so a reduction avoids indexing with an unwritten tag.
  assign io_resp_yumi_o = |(src_resp_v_o & src_resp_yumi_i);
  assign retire         = io_resp_yumi_o;

  always_comb begin
    rr_d    = issue ? wrap_src(grant, 1) : rr_q;
    wptr_d  = issue ? next_ptr(wptr_q) : wptr_q;
    rptr_d  = retire ? next_ptr(rptr_q) : rptr_q;
    count_d = count_q;
    if (issue && !retire) count_d = count_q + cnt_w_lp'(1);
    else if (!issue && retire) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q    <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) tag_mem_q[wptr_q] <= grant;
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(io_resp_v_i && !tag_v))
    else $error("host io_resp_v_i asserted with no outstanding command");

endmodule
